otter_cu_fsm: RTL
=================

# otter_cu_fsm

Multi-cycle control unit for the RISC-V OTTER core, succeeding the fixed four-state fetch/execute/writeback controller. It sequences PC, register-file, CSR and dual-port-memory write and read enables per opcode. It adds four things:
- a ready handshake on both memory ports, so slow memory stalls the FSM;
- a parametrised reset-hold length;
- machine-mode interrupt entry at instruction boundaries;
- SYSTEM-opcode handling (CSR writes, `mret`).

## Interface
Parameters:
- `INIT_CYCLES`, 1: cycles spent in `st_INIT` asserting `reset` after `RST_N` deasserts; legal range 1 to 15.
- `MEM_HANDSHAKE`, 1: 1 = honour `mem_ready1`/`mem_ready2`; 0 = treat both as constant 1 (single-cycle memory).
- `INTR_EN`, 1: 0 = `intr` ignored; `st_INTR` unreachable.

Ports:
- `clk` input 1: the block's single clock; all state changes on its rising edge.
- `RST_N` input 1: reset, asynchronous and active-low; forces `st_INIT` and clears the init counter.
- `intr` input 1: external interrupt request, level-sensitive.
- `mie` input 1: global interrupt enable (`mstatus.MIE`) from the CSR file.
- `opcode` input 7: `ir[6:0]`.
- `func3` input 3: `ir[14:12]`; used only for SYSTEM.
- `mem_ready1` input 1: instruction-port read data valid.
- `mem_ready2` input 1: data-port read data valid / write accepted.
- `PC_WE` output 1: PC write enable.
- `RF_WE` output 1: register-file write enable.
- `memWE2` output 1: data-port write enable.
- `memRDEN1` output 1: instruction-port read enable.
- `memRDEN2` output 1: data-port read enable.
- `csr_WE` output 1: CSR file write enable.
- `int_taken` output 1: interrupt entry (CSR file saves `mepc`, clears MIE; PC mux selects `mtvec`).
- `mret_exec` output 1: `mret` executing (CSR file restores MIE; PC mux selects `mepc`).
- `reset` output 1: datapath reset.

## Operation
- **Outputs:** all outputs are combinational from PS plus the inputs. Every output defaults to 0 in each state.
- **Reset:** while `RST_N`=0, `reset`=1 and every other output is 0.
- **`st_INIT`:**
  - `reset`=1.
  - Stays for `INIT_CYCLES` cycles, then goes to `st_FET`.
- **`st_FET`:**
  - `memRDEN1`=1.
  - Goes to `st_EX` when `mem_ready1`=1, else stays.
- **`st_EX`**, by opcode:
  - **LOAD:** `memRDEN2`=1, go to `st_MEM`.
  - **STORE:** `memWE2`=1. When `mem_ready2`=1, also `PC_WE`=1 and end the instruction. Otherwise stay in `st_EX` with `memWE2` held.
  - **BRANCH, JALR, JAL, LUI, AUIPC, OP_IMM, OP_RG3:** `PC_WE`=1. `RF_WE`=1 for all of these except BRANCH. End the instruction.
  - **SYSTEM (`7'b1110011`), `func3`=000:** `PC_WE`=1 and `mret_exec`=1. End the instruction.
  - **SYSTEM, `func3`≠000:** `PC_WE`=1, `RF_WE`=1, `csr_WE`=1. End the instruction.
  - **Any other opcode:** `PC_WE`=1 only (NOP). End the instruction.
- **`st_MEM`:**
  - `memRDEN2`=1.
  - Goes to `st_WB` when `mem_ready2`=1, else stays.
- **`st_WB`:**
  - `RF_WE`=1, `PC_WE`=1.
  - End the instruction.
- **End of instruction:**
  - If `INTR_EN` and `intr` and `mie` are all 1 in that cycle, NS=`st_INTR`; otherwise NS=`st_FET`.
- **`st_INTR`:**
  - `int_taken`=1, `PC_WE`=1.
  - Goes to `st_FET`.
- **Interrupt sampling:**
  - `intr` is sampled only in end-of-instruction cycles.
  - An interrupt is never taken mid-instruction or during `st_INIT`.
  - A request that drops before a boundary is lost; `intr` is level-sensitive.
- **`mret` with `intr` pending:** the boundary test uses the `mie` value in the `mret` cycle (still 0 in handler), so the interrupt is taken after the next instruction.
- **`RST_N` low in any state:** immediate abort to `st_INIT`; no partial writes are required to complete.
- **`PS` encoding:** 3-bit enum with states `st_INIT`, `st_FET`, `st_EX`, `st_MEM`, `st_WB`, `st_INTR`. Unused encodings go to `st_INIT`.

## Timing
- Latency with ready=1 and no interrupt:
  - ALU / branch / jump / CSR: 2 cycles.
  - Store: 2 cycles.
  - Load: 4 cycles.
- Each cycle that ready is 0 adds one cycle.
- Interrupt entry adds 1 cycle (`st_INTR`).
- After `RST_N` rises, first `memRDEN1`=1 occurs `INIT_CYCLES` cycles later.
- Ready handshake:
  - Enables are held constant until ready is seen.
  - Ready is ignored in states that do not assert the matching enable.
- At most one of `PC_WE`-causing paths is active per cycle.
- `int_taken` and `mret_exec` are never both 1.

## Structure
- Shared package `otter_pkg` holds:
  - `opcode_t`, with SYSTEM added to the existing nine opcodes;
  - `cu_state_t`;
  - `FUNC3_PRIV` = 3'b000.
- The CSR file and PC mux import the same package.
- No sub-module: the init counter (4-bit) is inline.

## Test plan
- Reset hold: `INIT_CYCLES`=3, release `RST_N` → `reset`=1 for exactly 3 cycles, then `memRDEN1`=1.
- Load with wait: LOAD, `mem_ready2` low 2 cycles → `memRDEN2` held 3 cycles, then `RF_WE`=`PC_WE`=1 for one cycle; load total 6 cycles.
- Store stall: STORE, `mem_ready2`=0 for 1 cycle → `memWE2` held 2 cycles, `PC_WE` only in the second.
- Interrupt: `intr`=`mie`=1 during OP_IMM `st_EX` → next cycle `int_taken`=`PC_WE`=1, then `st_FET`. Same with `mie`=0 → no `st_INTR`. Same with `INTR_EN`=0 → no `st_INTR`.
- SYSTEM: `func3`=001 → `csr_WE`=`RF_WE`=`PC_WE`=1. `func3`=000 → `mret_exec`=1, `RF_WE`=0.
- Async reset: drop `RST_N` mid-`st_MEM` (between edges) → outputs clear and `reset`=1 before the next edge.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared OTTER definitions: opcode encodings, control-unit states and the
// func3 value that marks privileged SYSTEM instructions (mret).
package otter_pkg;

    typedef enum logic [6:0] {
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        BRANCH = 7'b1100011,
        JALR   = 7'b1100111,
        JAL    = 7'b1101111,
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        OP_IMM = 7'b0010011,
        OP_RG3 = 7'b0110011,
        SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        st_INIT = 3'd0,
        st_FET  = 3'd1,
        st_EX   = 3'd2,
        st_MEM  = 3'd3,
        st_WB   = 3'd4,
        st_INTR = 3'd5
    } cu_state_t;

    localparam logic [2:0] FUNC3_PRIV = 3'b000;

endpackage

// File: rtl/otter_cu_fsm.sv
// Multi-cycle OTTER control unit: sequences fetch, execute, memory and
// writeback, stalls on memory ready, and enters the trap handler at
// instruction boundaries. Outputs are decoded combinationally from the
// present state and the current inputs.
module otter_cu_fsm
    import otter_pkg::*;
#(
    parameter int unsigned INIT_CYCLES   = 1,
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter bit          INTR_EN       = 1'b1
) (
    input  logic       clk,
    input  logic       RST_N,
    input  logic       intr,
    input  logic       mie,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       mem_ready1,
    input  logic       mem_ready2,
    output logic       PC_WE,
    output logic       RF_WE,
    output logic       memWE2,
    output logic       memRDEN1,
    output logic       memRDEN2,
    output logic       csr_WE,
    output logic       int_taken,
    output logic       mret_exec,
    output logic       reset
);

    localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

    cu_state_t  ps_q;
    cu_state_t  ns_d;
    logic [3:0] init_cnt_q;
    logic       rdy1;
    logic       rdy2;
    logic       take_int;
    opcode_t    op;

    // With single-cycle memory the ready inputs are ignored entirely.
    assign rdy1     = MEM_HANDSHAKE ? mem_ready1 : 1'b1;
    assign rdy2     = MEM_HANDSHAKE ? mem_ready2 : 1'b1;
    // Only consulted in end-of-instruction cycles below.
    assign take_int = INTR_EN && intr && mie;
    assign op       = opcode_t'(opcode);

    // State register and reset-hold counter; counter runs only while in INIT.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            ps_q       <= st_INIT;
            init_cnt_q <= 4'd0;
        end else begin
            ps_q <= ns_d;
            if (ps_q == st_INIT && ns_d == st_INIT)
                init_cnt_q <= init_cnt_q + 4'd1;
            else
                init_cnt_q <= 4'd0;
        end
    end

    // Next-state and output decode; every output defaults low in each state.
    always_comb begin
        ns_d      = st_INIT;
        PC_WE     = 1'b0;
        RF_WE     = 1'b0;
        memWE2    = 1'b0;
        memRDEN1  = 1'b0;
        memRDEN2  = 1'b0;
        csr_WE    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
        reset     = 1'b0;
        case (ps_q)
            st_INIT: begin
                reset = 1'b1;
                ns_d  = (init_cnt_q == INIT_LAST) ? st_FET : st_INIT;
            end
            st_FET: begin
                memRDEN1 = 1'b1;
                ns_d     = rdy1 ? st_EX : st_FET;
            end
            st_EX: begin
                // Default: instruction completes this cycle.
                ns_d = take_int ? st_INTR : st_FET;
                case (op)
                    LOAD: begin
                        memRDEN2 = 1'b1;
                        ns_d     = st_MEM;
                    end
                    STORE: begin
                        memWE2 = 1'b1;
                        if (rdy2) PC_WE = 1'b1;
                        else      ns_d  = st_EX;
                    end
                    BRANCH: PC_WE = 1'b1;
                    JALR, JAL, LUI, AUIPC, OP_IMM, OP_RG3: begin
                        PC_WE = 1'b1;
                        RF_WE = 1'b1;
                    end
                    SYSTEM: begin
                        PC_WE = 1'b1;
                        if (func3 == FUNC3_PRIV) begin
                            mret_exec = 1'b1;
                        end else begin
                            RF_WE  = 1'b1;
                            csr_WE = 1'b1;
                        end
                    end
                    default: PC_WE = 1'b1;
                endcase
            end
            st_MEM: begin
                memRDEN2 = 1'b1;
                ns_d     = rdy2 ? st_WB : st_MEM;
            end
            st_WB: begin
                RF_WE = 1'b1;
                PC_WE = 1'b1;
                ns_d  = take_int ? st_INTR : st_FET;
            end
            st_INTR: begin
                int_taken = 1'b1;
                PC_WE     = 1'b1;
                ns_d      = st_FET;
            end
            default: ns_d = st_INIT;
        endcase
    end

endmodule
